// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the CPU run/step controller.
// The debounce counter counts up from 0 to DEBOUNCE_MAX-1 before the level is accepted.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_STOP   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_MAX = 500_000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/step_ctrl_if.sv
// Signal bundle between the run/step controller and the CPU/board side.
interface step_ctrl_if;
  logic        slow_clk_in;
  logic        step_btn;
  logic        run_sw;
  logic        halt_req;
  logic        cpu_en;
  logic        halted;
  logic        running;
  logic [31:0] instr_count;

  modport master (
    output slow_clk_in, step_btn, run_sw, halt_req,
    input  cpu_en, halted, running, instr_count
  );

  modport slave (
    input  slow_clk_in, step_btn, run_sw, halt_req,
    output cpu_en, halted, running, instr_count
  );
endinterface

// File: rtl/step_ctrl_btn_debounce.sv
// Synchronizer plus consecutive-cycle debouncer for the single-step button.
// rise_pulse is high for one cycle when the accepted level goes 0->1.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_MAX = DEF_DEBOUNCE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int            CW       = cnt_width(DEBOUNCE_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MAX - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_in};
      rise_pulse <= 1'b0;
      // Any cycle of agreement restarts the stability window.
      if (btn_s == level_out) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q      <= '0;
        level_out  <= btn_s;
        rise_pulse <= btn_s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// Run/step/halt controller producing a one-cycle clock enable for a single-cycle CPU.
// Free-run advances on each slow clock rising edge, stop mode on each debounced button press.
//   state    | meaning
//   S_STOP   | idle, one instruction per step press
//   S_RUN    | free run, one instruction per slow clock tick
//   S_HALTED | CPU requested halt, only reset leaves
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_MAX = DEF_DEBOUNCE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  step_ctrl_if.slave  bus
);

  logic [SYNC_STAGES-1:0] slow_sync_q;
  logic [SYNC_STAGES-1:0] run_sync_q;
  logic                   slow_prev_q;
  logic                   slow_s;
  logic                   run_s;
  logic                   tick;
  logic                   btn_level;
  logic                   btn_rise;
  logic                   step_evt;

  state_t                 state_q;
  state_t                 state_d;
  logic                   pulse_d;
  logic                   cpu_en_q;
  logic [31:0]            instr_count_q;

  assign slow_s   = slow_sync_q[SYNC_STAGES-1];
  assign run_s    = run_sync_q[SYNC_STAGES-1];
  assign tick     = slow_s & ~slow_prev_q;
  assign step_evt = btn_rise & btn_level;

  btn_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_MAX (DEBOUNCE_MAX)
  ) u_btn_debounce (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (bus.step_btn),
    .level_out  (btn_level),
    .rise_pulse (btn_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slow_sync_q <= '0;
      run_sync_q  <= '0;
      slow_prev_q <= 1'b0;
    end else begin
      slow_sync_q <= {slow_sync_q[SYNC_STAGES-2:0], bus.slow_clk_in};
      run_sync_q  <= {run_sync_q[SYNC_STAGES-2:0], bus.run_sw};
      slow_prev_q <= slow_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Pulse decision uses the current state; a halt in the same cycle wins over any pulse.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    case (state_q)
      S_STOP: begin
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else begin
          pulse_d = step_evt;
          if (run_s) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else begin
          pulse_d = tick;
          if (!run_s) state_d = S_STOP;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_STOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_en_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      cpu_en_q      <= pulse_d;
      instr_count_q <= instr_count_q + {31'd0, cpu_en_q};
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.instr_count = instr_count_q;
  assign bus.running     = (state_q == S_RUN);
  assign bus.halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: stimulus queues expected pulses, a monitor matches each cpu_en pulse.
module tb_step_ctrl;
  import step_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  step_ctrl_if bus ();

  step_ctrl #(
    .SYNC_STAGES  (2),
    .DEBOUNCE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every observed pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.cpu_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d count %0h expected no pulse", cyc, bus.instr_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_count", bus.instr_count, e.cnt);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int delay, input logic [31:0] cnt);
    exp_t e;
    e.cyc = cyc + delay;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // One slow clock period of 20 cycles; a pulse, if any, lands 3 edges after the rise.
  task automatic slow_tick(input bit expect_pulse, input logic [31:0] cnt);
    bus.slow_clk_in = 1'b1;
    if (expect_pulse) push_exp(3, cnt);
    cycles(10);
    bus.slow_clk_in = 1'b0;
    cycles(10);
  endtask

  // Bounce 1/0/1 then hold; the debounced press completes 7 edges after the final rise.
  task automatic press(input bit expect_pulse, input logic [31:0] cnt);
    bus.step_btn = 1'b1;
    cycles(1);
    bus.step_btn = 1'b0;
    cycles(1);
    bus.step_btn = 1'b1;
    if (expect_pulse) push_exp(7, cnt);
    cycles(10);
    bus.step_btn = 1'b0;
    cycles(10);
  endtask

  task automatic chk_pending(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bus.slow_clk_in = 1'b0;
    bus.step_btn    = 1'b0;
    bus.run_sw      = 1'b0;
    bus.halt_req    = 1'b0;
    reset           = 1'b1;
    cycles(3);
    chk("rst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    chk("rst_running", {31'd0, bus.running}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_count", bus.instr_count, 32'd0);
    reset = 1'b0;
    cycles(2);

    // Free run: five ticks, then a step press that must be discarded.
    bus.run_sw = 1'b1;
    cycles(5);
    chk("run_running", {31'd0, bus.running}, 32'd1);
    for (int i = 0; i < 5; i++) slow_tick(1'b1, 32'(i));
    chk("run_count", bus.instr_count, 32'd5);
    press(1'b0, 32'd0);
    chk("run_step_ignored", bus.instr_count, 32'd5);
    chk_pending("pending_run");

    // Back to stop between ticks: ticks ignored, a press advances once.
    bus.run_sw = 1'b0;
    cycles(5);
    chk("stop_running", {31'd0, bus.running}, 32'd0);
    slow_tick(1'b0, 32'd0);
    slow_tick(1'b0, 32'd0);
    chk("stop_tick_ignored", bus.instr_count, 32'd5);
    press(1'b1, 32'd5);
    chk("stop_step_count", bus.instr_count, 32'd6);
    chk_pending("pending_stop");

    // Halt request in the cycle the tick is detected.
    bus.run_sw = 1'b1;
    cycles(5);
    chk("halt_pre_running", {31'd0, bus.running}, 32'd1);
    bus.slow_clk_in = 1'b1;
    cycles(2);
    bus.halt_req = 1'b1;
    cycles(1);
    bus.halt_req = 1'b0;
    chk("halt_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_running", {31'd0, bus.running}, 32'd0);
    cycles(8);
    bus.slow_clk_in = 1'b0;
    cycles(10);
    slow_tick(1'b0, 32'd0);
    slow_tick(1'b0, 32'd0);
    press(1'b0, 32'd0);
    bus.run_sw = 1'b0;
    cycles(5);
    chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
    chk("halt_count", bus.instr_count, 32'd6);
    chk_pending("pending_halt");

    // Reset asserted in the cycle a tick is detected.
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    bus.run_sw = 1'b1;
    cycles(5);
    chk("rtick_pre_running", {31'd0, bus.running}, 32'd1);
    bus.slow_clk_in = 1'b1;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    chk("rtick_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
    chk("rtick_running", {31'd0, bus.running}, 32'd0);
    chk("rtick_halted", {31'd0, bus.halted}, 32'd0);
    chk("rtick_count", bus.instr_count, 32'd0);
    cycles(1);
    reset = 1'b0;
    cycles(10);
    chk("rtick_post_count", bus.instr_count, 32'd0);
    bus.slow_clk_in = 1'b0;
    cycles(10);
    chk_pending("pending_rtick");

    // Counter wrap from all ones.
    chk("wrap_pre_running", {31'd0, bus.running}, 32'd1);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    cycles(1);
    release dut.instr_count_q;
    cycles(1);
    chk("wrap_preload", bus.instr_count, 32'hFFFF_FFFF);
    slow_tick(1'b1, 32'hFFFF_FFFF);
    chk("wrap_count", bus.instr_count, 32'd0);
    chk_pending("pending_wrap");

    // Short bounce alone is rejected; a held press gives exactly one pulse.
    bus.run_sw = 1'b0;
    cycles(5);
    chk("bounce_running", {31'd0, bus.running}, 32'd0);
    bus.step_btn = 1'b1;
    cycles(1);
    bus.step_btn = 1'b0;
    cycles(1);
    bus.step_btn = 1'b1;
    cycles(1);
    bus.step_btn = 1'b0;
    cycles(10);
    chk("bounce_only_count", bus.instr_count, 32'd0);
    press(1'b1, 32'd0);
    chk("bounce_press_count", bus.instr_count, 32'd1);
    chk_pending("pending_bounce");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each asynchronous input (minimum 2).
REQ-002 The module SHALL have parameter DEBOUNCE_MAX, default 500_000, meaning the consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 slow_clk_in  input  1  divided run-rate clock from the clock divider, asynchronous to clk.
REQ-006 step_btn  input  1  raw single-step push button, asynchronous, bouncing.
REQ-007 run_sw  input  1  mode switch, asynchronous: 1 = free run, 0 = single step.
REQ-008 halt_req  input  1  synchronous halt request from the CPU (e.g. ebreak/ecall), level.
REQ-009 cpu_en  output  1  one-cycle clock-enable pulse that advances the single-cycle CPU by one instruction.
REQ-010 halted  output  1  high while the FSM is in S_HALTED.
REQ-011 running  output  1  high while the FSM is in S_RUN.
REQ-012 instr_count  output  32  number of cpu_en pulses issued since reset.

Function
REQ-013 slow_clk_in, step_btn and run_sw SHALL each pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-014 A tick SHALL be a rising edge of synchronized slow_clk_in (current sample 1, previous sample 0).
REQ-015 The debounced button level SHALL change only after the synchronized step_btn has differed from it for DEBOUNCE_MAX consecutive cycles; any cycle of agreement clears the counter.
REQ-016 A step event SHALL be a 0->1 transition of the debounced button level.
REQ-017 The FSM SHALL have exactly the states S_STOP, S_RUN and S_HALTED.
REQ-018 From S_STOP: halt_req=1 -> S_HALTED; otherwise synchronized run_sw=1 -> S_RUN; otherwise stay.
REQ-019 From S_RUN: halt_req=1 -> S_HALTED; otherwise synchronized run_sw=0 -> S_STOP; otherwise stay.
REQ-020 S_HALTED SHALL be left only by reset.
REQ-021 cpu_en SHALL be registered and asserted for exactly one cycle: in S_RUN on each tick, and in S_STOP on each step event; never in S_HALTED.
REQ-022 The pulse decision SHALL use the current state; if halt_req=1 in the same cycle as a tick or step event, no pulse is issued.
REQ-023 With SYNC_STAGES=2, cpu_en SHALL rise 3 clk edges after slow_clk_in rises, given the input is stable across the sampling edge.
REQ-024 Step events in S_RUN and ticks in S_STOP SHALL be discarded, not queued.
REQ-025 instr_count SHALL increment by 1 in the cycle after each cpu_en pulse and wrap from 0xFFFF_FFFF to 0.
REQ-026 running and halted SHALL be decoded directly from the state register, with no added latency.

Reset
REQ-027 On reset the block SHALL set state=S_STOP, cpu_en=0, halted=0, running=0 and instr_count=0.
REQ-028 Reset SHALL clear all synchronizer flops, the edge-detect history, the debounce counter and the debounced level to 0.
REQ-029 A reset asserted mid-pulse or mid-debounce SHALL abort it; no pulse is issued in the cycle after reset deasserts.

Structure
REQ-030 The package step_ctrl_pkg SHALL hold the state enum (S_STOP, S_RUN, S_HALTED) and the default SYNC_STAGES and DEBOUNCE_MAX constants.
REQ-031 Button synchronization and debouncing SHALL be a sub-module btn_debounce (ports clk, reset, btn_in, level_out, rise_pulse), instantiated once.
REQ-032 All sequential logic SHALL run on posedge clk only; slow_clk_in SHALL never be used as a clock.

Verification (bench uses DEBOUNCE_MAX=4, SYNC_STAGES=2)
REQ-033 Set run_sw=1 and toggle slow_clk_in with period 20 clk -> 5 single-cycle cpu_en pulses in 100 cycles, each 3 cycles after a rising edge; instr_count=5.
REQ-034 With run_sw=0, bounce step_btn 1/0/1 in 1-cycle steps, then hold it at 1 for 10 cycles -> exactly one cpu_en pulse and instr_count=1; the bounces alone produce no pulse.
REQ-035 In S_RUN, assert halt_req in the cycle of a tick -> no pulse, halted=1, and no further pulses on later ticks or step presses until reset.
REQ-036 Preload instr_count to 0xFFFF_FFFF by force, then issue one tick -> instr_count=0.
REQ-037 Assert reset in the cycle a tick is detected -> cpu_en=0, state=S_STOP, instr_count=0, and no pulse after reset is released.
REQ-038 Toggle run_sw 1->0 between ticks -> pulses stop, running=0, and a later step press yields one pulse.
